// File: rtl/water_tank_level_matrix_scanner.sv
// water_tank_level_matrix_scanner
//
// Column-scanned LED-matrix driver for the water tank level image. The tank
// level is latched once per frame. Each frame draws two wall columns plus
// interior fill bars that rise from the bottom row. When the tank is empty,
// the walls blink.
//
// Ports:
//   clk_i                system clock
//   rst_i                asynchronous active-high reset
//   enable_i             scan enable; low freezes scanning and blanks rows
//   tank_level_status_i  current level, 0 = empty, 2^LEVEL_W-1 = full
//   column_select_o      one-hot active-high column drive
//   rows_status_o        row drive, active-low (0 = LED lit), bit ROWS-1 = bottom
//   frame_start_o        one-cycle pulse when column 0 is driven
module water_tank_level_matrix_scanner #(
  parameter int unsigned COLS         = 5,
  parameter int unsigned ROWS         = 7,
  parameter int unsigned LEVEL_W      = 2,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [LEVEL_W-1:0] tank_level_status_i,
  output logic [COLS-1:0]    column_select_o,
  output logic [ROWS-1:0]    rows_status_o,
  output logic               frame_start_o
);

  localparam int unsigned DivW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ColW     = $clog2(COLS);
  localparam int unsigned FrmW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned LevelMax = (1 << LEVEL_W) - 1;

  logic [DivW-1:0]    div_q, div_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [FrmW-1:0]    frm_q, frm_d;
  logic               blink_q, blink_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [COLS-1:0]    sel_q, sel_d;
  logic [ROWS-1:0]    rows_q, rows_d;
  logic               fs_q, fs_d;

  // Active-low row image for one column.
  function automatic logic [ROWS-1:0] col_image(input logic [ColW-1:0]    col,
                                                input logic [LEVEL_W-1:0] level,
                                                input logic               blink);
    int unsigned     fill;
    logic [ROWS-1:0] img;
    img  = '1;
    fill = 0;
    if (col == '0 || col == ColW'(COLS - 1)) begin
      img = (level == '0 && blink) ? '1 : '0;
    end else begin
      if (level != '0) begin
        fill = (32'(level) * ROWS) / LevelMax;
        // Any non-empty level shows at least one row.
        if (fill == 0) fill = 1;
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (r >= ROWS - fill) img[r] = 1'b0;
      end
    end
    return img;
  endfunction

  always_comb begin
    div_d   = div_q;
    col_d   = col_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    level_d = level_q;
    sel_d   = sel_q;
    rows_d  = rows_q;
    fs_d    = 1'b0;
    if (!enable_i) begin
      rows_d = '1;
    end else if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_d = '0;
      col_d = (col_q == ColW'(COLS - 1)) ? '0 : col_q + ColW'(1);
      if (col_d == '0) begin
        // Frame boundary: latch the level so a frame never mixes two levels.
        level_d = tank_level_status_i;
        fs_d    = 1'b1;
        if (frm_q == FrmW'(BLINK_FRAMES - 1)) begin
          frm_d   = '0;
          blink_d = ~blink_q;
        end else begin
          frm_d = frm_q + FrmW'(1);
        end
      end
      sel_d  = COLS'(1) << col_d;
      rows_d = col_image(col_d, level_d, blink_d);
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      col_q   <= ColW'(COLS - 1);
      frm_q   <= '0;
      blink_q <= 1'b0;
      level_q <= '0;
      sel_q   <= '0;
      rows_q  <= '1;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      level_q <= level_d;
      sel_q   <= sel_d;
      rows_q  <= rows_d;
      fs_q    <= fs_d;
    end
  end

  assign column_select_o = sel_q;
  assign rows_status_o   = rows_q;
  assign frame_start_o   = fs_q;

endmodule

// File: tb/tb_water_tank_level_matrix_scanner.sv
// Testbench for water_tank_level_matrix_scanner: a reference model pushes the
// expected outputs of every clock into a scoreboard, which is popped and
// compared on the falling edge; directed steps add point checks.
module tb_water_tank_level_matrix_scanner;

  localparam int unsigned COLS         = 5;
  localparam int unsigned ROWS         = 7;
  localparam int unsigned LEVEL_W      = 2;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLINK_FRAMES = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       enable_i = 1'b0;
  logic [1:0] lvl = 2'd0;
  logic [4:0] sel;
  logic [6:0] rows;
  logic       fs;

  int tests = 0;
  int fails = 0;

  water_tank_level_matrix_scanner #(
    .COLS(COLS), .ROWS(ROWS), .LEVEL_W(LEVEL_W), .SCAN_DIV(SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .tank_level_status_i(lvl),
    .column_select_o(sel),
    .rows_status_o(rows),
    .frame_start_o(fs)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] sel;
    logic [6:0] rows;
    logic       fs;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected active-low image; fill table for 7 rows / max level 3 is 0,2,4,7.
  function automatic logic [6:0] model_rows(input int c, input logic [1:0] l, input bit b);
    if (c == 0 || c == COLS - 1) return (l == 2'd0 && b) ? 7'h7f : 7'h00;
    case (l)
      2'd0:    return 7'h7f;
      2'd1:    return 7'h1f;
      2'd2:    return 7'h07;
      default: return 7'h00;
    endcase
  endfunction

  int         m_div, m_col, m_frm;
  bit         m_blink;
  logic [1:0] m_lvl;
  logic [4:0] m_sel;
  logic [6:0] m_rows;
  logic       m_fs;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_div = 0; m_col = COLS - 1; m_frm = 0; m_blink = 0; m_lvl = 2'd0;
      m_sel = 5'd0; m_rows = 7'h7f; m_fs = 1'b0;
      sb.delete();
    end else begin
      m_fs = 1'b0;
      if (!enable_i) begin
        m_rows = 7'h7f;
      end else if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_col = (m_col == COLS - 1) ? 0 : m_col + 1;
        if (m_col == 0) begin
          m_lvl = lvl;
          m_fs  = 1'b1;
          if (m_frm == BLINK_FRAMES - 1) begin
            m_frm = 0;
            m_blink = !m_blink;
          end else begin
            m_frm++;
          end
        end
        m_sel  = 5'd1 << m_col;
        m_rows = model_rows(m_col, m_lvl, m_blink);
      end else begin
        m_div++;
      end
    end
    sb.push_back('{m_sel, m_rows, m_fs});
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_column_select", 32'(sel), 32'(e.sel));
      chk("sb_rows_status", 32'(rows), 32'(e.rows));
      chk("sb_frame_start", 32'(fs), 32'(e.fs));
    end
  end

  task automatic wait_sel(input logic [4:0] t, input int max);
    int n = 0;
    while (sel !== t && n < max) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("wait_column_select", 32'(sel), 32'(t));
  endtask

  task automatic wait_fs(input int max);
    int n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (fs !== 1'b1 && n < max);
    chk("wait_frame_start", 32'(fs), 32'd1);
  endtask

  initial begin
    int lit, dark;
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("reset_column_select", 32'(sel), 32'h00);
    chk("reset_rows_status", 32'(rows), 32'h7f);
    chk("reset_frame_start", 32'(fs), 32'd0);

    // First tick at edge SCAN_DIV after release: column 0, full tank.
    lvl = 2'd3; enable_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 chk("pre_tick_column_select", 32'(sel), 32'h00);
    @(posedge clk_i); #1;
    chk("first_column_select", 32'(sel), 32'h01);
    chk("first_frame_start", 32'(fs), 32'd1);
    chk("first_rows_status", 32'(rows), 32'h00);
    repeat (40) @(posedge clk_i);

    // Level 1 and level 2 images.
    #1 lvl = 2'd1;
    wait_fs(30);
    wait_sel(5'b00100, 30);
    chk("lvl1_interior_rows", 32'(rows), 32'h1f);
    wait_sel(5'b10000, 30);
    chk("lvl1_wall_rows", 32'(rows), 32'h00);
    lvl = 2'd2;
    wait_fs(30);
    chk("lvl2_wall_rows", 32'(rows), 32'h00);
    wait_sel(5'b01000, 30);
    chk("lvl2_interior_rows", 32'(rows), 32'h07);

    // Mid-frame level change is deferred to the next frame.
    lvl = 2'd3;
    wait_fs(30);
    wait_fs(30);
    wait_sel(5'b00100, 30);
    lvl = 2'd1;
    wait_sel(5'b01000, 30);
    chk("tear_col3_rows", 32'(rows), 32'h00);
    wait_sel(5'b10000, 30);
    chk("tear_col4_rows", 32'(rows), 32'h00);
    wait_fs(30);
    wait_sel(5'b00010, 30);
    chk("tear_next_frame_rows", 32'(rows), 32'h1f);

    // Enable dropped during column 2 for 10 cycles.
    wait_sel(5'b00100, 30);
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    chk("disable_rows_status", 32'(rows), 32'h7f);
    chk("disable_column_select", 32'(sel), 32'h04);
    repeat (9) @(posedge clk_i);
    #1 chk("disable_hold_select", 32'(sel), 32'h04);
    enable_i = 1'b1;
    wait_sel(5'b01000, 10);
    chk("reenable_col3_rows", 32'(rows), 32'h1f);

    // Empty tank: walls blink with a 2-frame half-period.
    lvl = 2'd0;
    wait_fs(30);
    lit = 0; dark = 0;
    for (int i = 0; i < 8; i++) begin
      wait_fs(30);
      if (rows === 7'h00) lit++;
      else if (rows === 7'h7f) dark++;
    end
    chk("blink_lit_frames", 32'(lit), 32'd4);
    chk("blink_dark_frames", 32'(dark), 32'd4);
    wait_sel(5'b00100, 30);
    chk("empty_interior_rows", 32'(rows), 32'h7f);

    // Asynchronous reset mid-frame, then restart.
    lvl = 2'd3;
    wait_sel(5'b01000, 30);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_column_select", 32'(sel), 32'h00);
    chk("async_rst_rows_status", 32'(rows), 32'h7f);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 chk("restart_no_early_fs", 32'(fs), 32'd0);
    @(posedge clk_i); #1;
    chk("restart_frame_start", 32'(fs), 32'd1);
    chk("restart_column_select", 32'(sel), 32'h01);
    repeat (25) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
